// File: rtl/ls_queue.sv
// ls_queue: in-order load/store queue between dispatcher and LSU.
// Circular buffer of memory ops in program order. Snoops the result buses for
// pending operands and issues the head entry. Loads go once operands are ready
// (IO loads only at ROB head). Stores go only after ROB commit.
// Optional: define LSQ_STATS_EN to add issue/stall statistics counters.
module ls_queue #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ROB_W       = 4,
    parameter int unsigned OP_W        = 6,
    parameter int unsigned NCDB        = 2,
    parameter int unsigned FULL_MARGIN = 3,
    parameter logic [DATA_W-1:0] IO_ADDR = DATA_W'(32'h30000)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   alloc_valid,
    input  logic                   alloc_store,
    input  logic [OP_W-1:0]        alloc_op,
    input  logic [ROB_W-1:0]       alloc_q1,
    input  logic [ROB_W-1:0]       alloc_q2,
    input  logic [DATA_W-1:0]      alloc_v1,
    input  logic [DATA_W-1:0]      alloc_v2,
    input  logic [DATA_W-1:0]      alloc_imm,
    input  logic [ROB_W-1:0]       alloc_rob,
    input  logic [NCDB-1:0]        cdb_valid,
    input  logic [NCDB*ROB_W-1:0]  cdb_rob,
    input  logic [NCDB*DATA_W-1:0] cdb_data,
    input  logic                   commit_valid,
    input  logic [ROB_W-1:0]       commit_rob,
    input  logic [ROB_W-1:0]       io_rob_head,
    input  logic                   flush,
    input  logic                   lsu_busy,
    output logic                   lsu_valid,
    output logic                   lsu_store,
    output logic [OP_W-1:0]        lsu_op,
    output logic [DATA_W-1:0]      lsu_addr,
    output logic [DATA_W-1:0]      lsu_wdata,
    output logic [ROB_W-1:0]       io_rob,
    output logic                   full
`ifdef LSQ_STATS_EN
    ,
    output logic [31:0]            stat_loads,
    output logic [31:0]            stat_stores,
    output logic [31:0]            stat_stall
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic              valid;
        logic              store;
        logic              committed;
        logic [OP_W-1:0]   op;
        logic [ROB_W-1:0]  q1;
        logic [ROB_W-1:0]  q2;
        logic [DATA_W-1:0] v1;
        logic [DATA_W-1:0] v2;
        logic [DATA_W-1:0] imm;
        logic [ROB_W-1:0]  rob;
    } entry_t;

    entry_t            ent_q [DEPTH];
    entry_t            ent_d [DEPTH];
    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              lsu_valid_q, lsu_valid_d;
    logic              lsu_store_q, lsu_store_d;
    logic [OP_W-1:0]   lsu_op_q, lsu_op_d;
    logic [DATA_W-1:0] lsu_addr_q, lsu_addr_d;
    logic [DATA_W-1:0] lsu_wdata_q, lsu_wdata_d;

    entry_t            head_ent;
    logic [DATA_W-1:0] head_addr;
    logic              head_ok;
    logic              do_issue;
    logic              do_alloc;
    entry_t            new_ent;
    logic [AW-1:0]     start;
    logic [AW-1:0]     idx;
    logic [CW-1:0]     kept;
    logic              in_prefix;

    // Resolve one operand against the result buses; the lowest matching bus wins.
    function automatic logic [ROB_W+DATA_W-1:0] resolve(
        input logic [ROB_W-1:0]       q,
        input logic [DATA_W-1:0]      v,
        input logic [NCDB-1:0]        bv,
        input logic [NCDB*ROB_W-1:0]  br,
        input logic [NCDB*DATA_W-1:0] bd
    );
        logic              hit;
        logic [ROB_W-1:0]  q_o;
        logic [DATA_W-1:0] v_o;
        hit = 1'b0;
        q_o = q;
        v_o = v;
        for (int unsigned k = 0; k < NCDB; k++) begin
            if (!hit && q != '0 && bv[k] && br[k*ROB_W +: ROB_W] == q) begin
                hit = 1'b1;
                q_o = '0;
                v_o = bd[k*DATA_W +: DATA_W];
            end
        end
        return {q_o, v_o};
    endfunction

    // Head issue decision from registered entry state, plus comb outputs.
    always_comb begin
        head_ent  = ent_q[head_q];
        head_addr = head_ent.v1 + head_ent.imm;
        if (head_ent.store) begin
            head_ok = head_ent.committed;
        end else begin
            head_ok = (head_addr != IO_ADDR) || (head_ent.rob == io_rob_head);
        end
        do_issue = rdy && head_ent.valid && head_ent.q1 == '0 && head_ent.q2 == '0
                   && !lsu_busy && head_ok;
        full     = count_q >= CW'(DEPTH - FULL_MARGIN);
        do_alloc = rdy && !flush && alloc_valid && !full;
        io_rob   = (head_ent.valid && head_addr == IO_ADDR) ? head_ent.rob : '0;
    end

    // Next-state: snoop, commit, issue, then either flush trimming or allocation.
    always_comb begin
        ent_d       = ent_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        lsu_valid_d = 1'b0;
        lsu_store_d = lsu_store_q;
        lsu_op_d    = lsu_op_q;
        lsu_addr_d  = lsu_addr_q;
        lsu_wdata_d = lsu_wdata_q;
        start       = head_q;
        idx         = '0;
        kept        = '0;
        in_prefix   = 1'b1;

        new_ent           = '0;
        new_ent.valid     = 1'b1;
        new_ent.store     = alloc_store;
        new_ent.op        = alloc_op;
        new_ent.v2        = alloc_v2;
        new_ent.imm       = alloc_imm;
        new_ent.rob       = alloc_rob;
        {new_ent.q1, new_ent.v1} = resolve(alloc_q1, alloc_v1, cdb_valid, cdb_rob, cdb_data);
        {new_ent.q2, new_ent.v2} = resolve(alloc_q2, alloc_v2, cdb_valid, cdb_rob, cdb_data);

        if (rdy) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (ent_q[i].valid) begin
                    {ent_d[i].q1, ent_d[i].v1} =
                        resolve(ent_q[i].q1, ent_q[i].v1, cdb_valid, cdb_rob, cdb_data);
                    {ent_d[i].q2, ent_d[i].v2} =
                        resolve(ent_q[i].q2, ent_q[i].v2, cdb_valid, cdb_rob, cdb_data);
                    if (commit_valid && ent_q[i].rob == commit_rob) begin
                        ent_d[i].committed = 1'b1;
                    end
                end
            end

            if (do_issue) begin
                ent_d[head_q].valid = 1'b0;
                head_d      = head_q + AW'(1);
                lsu_valid_d = 1'b1;
                lsu_store_d = head_ent.store;
                lsu_op_d    = head_ent.op;
                lsu_addr_d  = head_addr;
                lsu_wdata_d = head_ent.store ? head_ent.v2 : '0;
            end

            if (flush) begin
                // Walk from the post-issue head; committed stores (this cycle's
                // commit included) form the surviving prefix, everything after dies.
                start = head_q + AW'(do_issue);
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    idx = start + AW'(j);
                    if (in_prefix && ent_d[idx].valid && ent_d[idx].store && ent_d[idx].committed) begin
                        kept = kept + CW'(1);
                    end else begin
                        in_prefix         = 1'b0;
                        ent_d[idx].valid  = 1'b0;
                    end
                end
                tail_d  = start + kept[AW-1:0];
                count_d = kept;
            end else begin
                if (do_alloc) begin
                    ent_d[tail_q] = new_ent;
                    tail_d        = tail_q + AW'(1);
                end
                count_d = count_q + CW'(do_alloc) - CW'(do_issue);
            end
        end
    end

    // State and issue-output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            lsu_valid_q <= 1'b0;
            lsu_store_q <= 1'b0;
            lsu_op_q    <= '0;
            lsu_addr_q  <= '0;
            lsu_wdata_q <= '0;
        end else begin
            ent_q       <= ent_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            lsu_valid_q <= lsu_valid_d;
            lsu_store_q <= lsu_store_d;
            lsu_op_q    <= lsu_op_d;
            lsu_addr_q  <= lsu_addr_d;
            lsu_wdata_q <= lsu_wdata_d;
        end
    end

    assign lsu_valid = lsu_valid_q;
    assign lsu_store = lsu_store_q;
    assign lsu_op    = lsu_op_q;
    assign lsu_addr  = lsu_addr_q;
    assign lsu_wdata = lsu_wdata_q;

`ifdef LSQ_STATS_EN
    logic [31:0] stat_loads_q, stat_loads_d;
    logic [31:0] stat_stores_q, stat_stores_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Saturating statistics counters; flush does not clear them.
    always_comb begin
        stat_loads_d  = stat_loads_q;
        stat_stores_d = stat_stores_q;
        stat_stall_d  = stat_stall_q;
        if (do_issue && !head_ent.store && stat_loads_q != '1) begin
            stat_loads_d = stat_loads_q + 32'd1;
        end
        if (do_issue && head_ent.store && stat_stores_q != '1) begin
            stat_stores_d = stat_stores_q + 32'd1;
        end
        if (rdy && head_ent.valid && !do_issue && stat_stall_q != '1) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_loads_q  <= '0;
            stat_stores_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_loads_q  <= stat_loads_d;
            stat_stores_q <= stat_stores_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_loads  = stat_loads_q;
    assign stat_stores = stat_stores_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_ls_queue.sv
// tb_ls_queue: directed scenarios plus randomized traffic for ls_queue, checked
// every cycle against a queue-based reference model of the load/store queue.
module tb_ls_queue;

    localparam int unsigned DEPTH       = 16;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned ROB_W       = 4;
    localparam int unsigned OP_W        = 6;
    localparam int unsigned NCDB        = 2;
    localparam int unsigned FULL_MARGIN = 3;
    localparam logic [31:0] IO_ADDR     = 32'h30000;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        alloc_valid, alloc_store;
    logic [5:0]  alloc_op;
    logic [3:0]  alloc_q1, alloc_q2, alloc_rob;
    logic [31:0] alloc_v1, alloc_v2, alloc_imm;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_rob;
    logic [63:0] cdb_data;
    logic        commit_valid;
    logic [3:0]  commit_rob, io_rob_head;
    logic        flush, lsu_busy;
    logic        lsu_valid, lsu_store;
    logic [5:0]  lsu_op;
    logic [31:0] lsu_addr, lsu_wdata;
    logic [3:0]  io_rob;
    logic        full;

    ls_queue #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .ROB_W(ROB_W), .OP_W(OP_W),
        .NCDB(NCDB), .FULL_MARGIN(FULL_MARGIN), .IO_ADDR(IO_ADDR)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_store(alloc_store), .alloc_op(alloc_op),
        .alloc_q1(alloc_q1), .alloc_q2(alloc_q2), .alloc_v1(alloc_v1), .alloc_v2(alloc_v2),
        .alloc_imm(alloc_imm), .alloc_rob(alloc_rob),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_data(cdb_data),
        .commit_valid(commit_valid), .commit_rob(commit_rob), .io_rob_head(io_rob_head),
        .flush(flush), .lsu_busy(lsu_busy),
        .lsu_valid(lsu_valid), .lsu_store(lsu_store), .lsu_op(lsu_op),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .io_rob(io_rob), .full(full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          store;
        bit          committed;
        logic [5:0]  op;
        logic [3:0]  q1, q2, rob;
        logic [31:0] v1, v2, imm;
    } ment_t;

    ment_t       mq[$];
    logic        e_valid = 1'b0, e_store = 1'b0;
    logic [5:0]  e_op = '0;
    logic [31:0] e_addr = '0, e_wdata = '0;

    function automatic bit bus_match(input logic [3:0] q, output logic [31:0] v);
        v = '0;
        if (q == 4'd0) return 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (cdb_valid[k] && cdb_rob[k*4 +: 4] == q) begin
                v = cdb_data[k*32 +: 32];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic void snoop_ent(inout ment_t e);
        logic [31:0] d;
        if (bus_match(e.q1, d)) begin e.q1 = 4'd0; e.v1 = d; end
        if (bus_match(e.q2, d)) begin e.q2 = 4'd0; e.v2 = d; end
    endfunction

    function automatic logic [3:0] exp_io();
        if (mq.size() > 0 && (mq[0].v1 + mq[0].imm) == IO_ADDR) return mq[0].rob;
        return 4'd0;
    endfunction

    // Model update on each edge, then compare every DUT output just after it.
    always @(posedge clk) begin
        int    n0, nk;
        bit    iss;
        ment_t h, t, ne;
        if (rst) begin
            mq.delete();
            e_valid = 0; e_store = 0; e_op = '0; e_addr = '0; e_wdata = '0;
        end else if (!rdy) begin
            e_valid = 0;
        end else begin
            n0  = mq.size();
            iss = 0;
            if (n0 > 0) begin
                h = mq[0];
                if (h.q1 == 0 && h.q2 == 0 && !lsu_busy)
                    iss = h.store ? h.committed : ((h.v1 + h.imm) != IO_ADDR || h.rob == io_rob_head);
            end
            foreach (mq[i]) begin
                t = mq[i];
                snoop_ent(t);
                if (commit_valid && t.rob == commit_rob) t.committed = 1;
                mq[i] = t;
            end
            e_valid = iss;
            if (iss) begin
                e_store = h.store;
                e_op    = h.op;
                e_addr  = h.v1 + h.imm;
                e_wdata = h.store ? h.v2 : 32'd0;
                void'(mq.pop_front());
            end
            if (flush) begin
                nk = 0;
                while (nk < mq.size() && mq[nk].store && mq[nk].committed) nk++;
                while (mq.size() > nk) void'(mq.pop_back());
            end else if (alloc_valid && n0 < int'(DEPTH - FULL_MARGIN)) begin
                ne.store = alloc_store; ne.committed = 0; ne.op = alloc_op;
                ne.q1 = alloc_q1; ne.q2 = alloc_q2; ne.rob = alloc_rob;
                ne.v1 = alloc_v1; ne.v2 = alloc_v2; ne.imm = alloc_imm;
                snoop_ent(ne);
                mq.push_back(ne);
            end
        end
        #1;
        chk("lsu_valid", 32'(lsu_valid), 32'(e_valid));
        if (e_valid && lsu_valid) begin
            chk("lsu_store", 32'(lsu_store), 32'(e_store));
            chk("lsu_op", 32'(lsu_op), 32'(e_op));
            chk("lsu_addr", lsu_addr, e_addr);
            chk("lsu_wdata", lsu_wdata, e_wdata);
        end
        chk("full", 32'(full), 32'(mq.size() >= int'(DEPTH - FULL_MARGIN)));
        chk("io_rob", 32'(io_rob), 32'(exp_io()));
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        alloc_valid = 0; alloc_store = 0; alloc_op = '0;
        alloc_q1 = '0; alloc_q2 = '0; alloc_v1 = '0; alloc_v2 = '0;
        alloc_imm = '0; alloc_rob = '0;
        cdb_valid = '0; cdb_rob = '0; cdb_data = '0;
        commit_valid = 0; commit_rob = '0; flush = 0;
    endtask

    task automatic put(input bit st, input logic [3:0] q1, input logic [31:0] v1,
                       input logic [3:0] q2, input logic [31:0] v2,
                       input logic [31:0] imm, input logic [3:0] rob);
        alloc_valid = 1; alloc_store = st; alloc_op = 6'(rob + 4'd1);
        alloc_q1 = q1; alloc_v1 = v1; alloc_q2 = q2; alloc_v2 = v2;
        alloc_imm = imm; alloc_rob = rob;
    endtask

    initial begin
        int          n_iss, n_st;
        logic [31:0] last_addr;
        rst = 1; rdy = 1; lsu_busy = 0; io_rob_head = '0;
        idle_inputs();
        repeat (3) cyc();
        chk("rst_lsu_valid", 32'(lsu_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_io_rob", 32'(io_rob), 32'd0);
        rst = 0;
        cyc();

        // 1: ready load issues one cycle after allocation
        put(0, 4'd0, 32'h100, 4'd0, 32'h0, 32'd4, 4'd1);
        cyc(); idle_inputs();
        cyc();
        chk("t1_valid", 32'(lsu_valid), 32'd1);
        chk("t1_addr", lsu_addr, 32'h104);
        chk("t1_wdata", lsu_wdata, 32'h0);
        repeat (2) cyc();

        // 2: store waits for data, then for commit
        put(1, 4'd0, 32'h200, 4'd5, 32'h0, 32'd0, 4'd9);
        cyc(); idle_inputs();
        cdb_valid = 2'b01; cdb_rob = {4'd0, 4'd5}; cdb_data = {32'h0, 32'hAB};
        cyc(); idle_inputs();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t2_no_issue", 32'(lsu_valid), 32'd0);
        end
        commit_valid = 1; commit_rob = 4'd9;
        cyc(); idle_inputs();
        cyc();
        chk("t2_valid", 32'(lsu_valid), 32'd1);
        chk("t2_store", 32'(lsu_store), 32'd1);
        chk("t2_wdata", lsu_wdata, 32'hAB);
        repeat (2) cyc();

        // 3: alloc bypass from the result bus
        put(0, 4'd3, 32'h0, 4'd0, 32'h0, 32'd0, 4'd10);
        cdb_valid = 2'b01; cdb_rob = {4'd0, 4'd3}; cdb_data = {32'h0, 32'h20};
        cyc(); idle_inputs();
        cyc();
        chk("t3_valid", 32'(lsu_valid), 32'd1);
        chk("t3_addr", lsu_addr, 32'h20);
        repeat (2) cyc();

        // 4: flush keeps only the committed-store prefix
        lsu_busy = 1;
        put(1, 4'd0, 32'h400, 4'd0, 32'h11, 32'd0, 4'd1); cyc();
        put(1, 4'd0, 32'h404, 4'd0, 32'h22, 32'd0, 4'd2); cyc();
        put(0, 4'd0, 32'h40, 4'd0, 32'h0, 32'd0, 4'd3); cyc();
        put(0, 4'd0, 32'h44, 4'd0, 32'h0, 32'd0, 4'd4); cyc();
        put(0, 4'd0, 32'h48, 4'd0, 32'h0, 32'd0, 4'd5); cyc();
        idle_inputs();
        commit_valid = 1; commit_rob = 4'd1; cyc();
        commit_rob = 4'd2; cyc();
        idle_inputs(); flush = 1; cyc();
        idle_inputs(); lsu_busy = 0;
        n_iss = 0; n_st = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (lsu_valid) begin n_iss++; if (lsu_store) n_st++; end
        end
        chk("t4_issues", 32'(n_iss), 32'd2);
        chk("t4_stores", 32'(n_st), 32'd2);

        // 5: fill to the full threshold, drop the extra, drain across the wrap
        lsu_busy = 1;
        for (int i = 0; i < 14; i++) begin
            put(0, 4'd0, 32'(i * 4), 4'd0, 32'h0, 32'd0, 4'(i + 1));
            cyc();
            if (i == 11) chk("t5_not_full_12", 32'(full), 32'd0);
            if (i == 12) chk("t5_full_13", 32'(full), 32'd1);
        end
        idle_inputs(); lsu_busy = 0;
        n_iss = 0; last_addr = '0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (lsu_valid) begin n_iss++; last_addr = lsu_addr; end
        end
        chk("t5_drained", 32'(n_iss), 32'd13);
        chk("t5_last_addr", last_addr, 32'h30);
        chk("t5_full_clear", 32'(full), 32'd0);

        // 6: IO load waits for the ROB head
        io_rob_head = 4'd6;
        put(0, 4'd0, 32'h30000, 4'd0, 32'h0, 32'd0, 4'd7);
        cyc(); idle_inputs();
        cyc();
        chk("t6_io_rob", 32'(io_rob), 32'd7);
        chk("t6_blocked", 32'(lsu_valid), 32'd0);
        cyc();
        chk("t6_still_blocked", 32'(lsu_valid), 32'd0);
        io_rob_head = 4'd7;
        cyc();
        chk("t6_valid", 32'(lsu_valid), 32'd1);
        chk("t6_addr", lsu_addr, 32'h30000);
        chk("t6_io_rob_clear", 32'(io_rob), 32'd0);
        io_rob_head = '0;
        repeat (2) cyc();

        // Randomized traffic, model-checked every cycle
        for (int i = 0; i < 4000; i++) begin
            rst          = (i == 2000);
            rdy          = ($urandom_range(0, 9) != 0);
            lsu_busy     = ($urandom_range(0, 3) == 0);
            alloc_valid  = 1'($urandom_range(0, 1));
            alloc_store  = ($urandom_range(0, 2) == 0);
            alloc_op     = 6'($urandom);
            alloc_q1     = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            alloc_q2     = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            alloc_imm    = 32'($urandom_range(0, 255));
            alloc_v1     = ($urandom_range(0, 7) == 0) ? IO_ADDR - alloc_imm : 32'($urandom);
            alloc_v2     = 32'($urandom);
            alloc_rob    = 4'($urandom_range(1, 15));
            cdb_valid    = 2'($urandom);
            cdb_rob      = 8'($urandom);
            cdb_data     = {32'($urandom), 32'($urandom)};
            commit_valid = ($urandom_range(0, 2) == 0);
            commit_rob   = 4'($urandom_range(1, 15));
            io_rob_head  = 4'($urandom_range(0, 15));
            flush        = ($urandom_range(0, 39) == 0);
            cyc();
        end
        rst = 0; rdy = 1; lsu_busy = 0;
        idle_inputs();
        repeat (5) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
